// File: rtl/line_clear_unit.sv
// line_clear_unit: board-compaction stage behind the game-logic FSM.
// Scans the board RAM bottom-up, drops full rows, shifts survivors down,
// zero-fills the vacated top rows, and reports a full-row map plus count.
// Optional build macro: LINE_CLEAR_EARLY_EXIT_EN (an all-zero row ends the scan).
module line_clear_unit #(
  parameter int ROWS = 22,
  parameter int COLS = 10,
  parameter int AW   = 5,
  parameter int CW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [ROWS-1:0] full_rows,
  output logic [CW-1:0]   lines_cleared,
  output logic [AW-1:0]   rd_addr,
  input  logic [COLS-1:0] rd_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [COLS-1:0] wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EVAL,
    FILL,
    DONE
  } state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  state_t            state, state_n;
  logic [AW-1:0]     rp, rp_n;
  logic [AW-1:0]     wp, wp_n;
  logic [CW-1:0]     count, count_n;
  logic [ROWS-1:0]   full_n;
  logic [CW-1:0]     lines_n;
  logic [AW-1:0]     rd_addr_n;
  logic [AW-1:0]     fill_stop;
  logic              row_full;
  logic              row_empty;

  assign row_full  = &rd_data;
  assign row_empty = (rd_data == '0);

  // Last row FILL writes: row 0 on a full scan; with early exit the scan
  // stops at the empty row rp (rp is 0 anyway if the scan ran to the top).
`ifdef LINE_CLEAR_EARLY_EXIT_EN
  assign fill_stop = rp;
`else
  assign fill_stop = '0;
`endif

  // State register and datapath registers; reset aborts any scan in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rp            <= '0;
      wp            <= '0;
      count         <= '0;
      full_rows     <= '0;
      lines_cleared <= '0;
      rd_addr       <= '0;
    end else begin
      state         <= state_n;
      rp            <= rp_n;
      wp            <= wp_n;
      count         <= count_n;
      full_rows     <= full_n;
      lines_cleared <= lines_n;
      rd_addr       <= rd_addr_n;
    end
  end

  // Next-state, pointer updates and RAM write strobes.
  // rd_addr is registered one step ahead so it is on the bus during READ.
  always_comb begin
    state_n   = state;
    rp_n      = rp;
    wp_n      = wp;
    count_n   = count;
    full_n    = full_rows;
    lines_n   = lines_cleared;
    rd_addr_n = rd_addr;
    busy      = (state != IDLE);
    done      = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    case (state)
      IDLE: begin
        if (start) begin
          rp_n      = LAST_ROW;
          wp_n      = LAST_ROW;
          count_n   = '0;
          full_n    = '0;
          rd_addr_n = LAST_ROW;
          state_n   = READ;
        end
      end

      READ: begin
        state_n = EVAL;
      end

      EVAL: begin
`ifdef LINE_CLEAR_EARLY_EXIT_EN
        if (row_empty) begin
          state_n = FILL;
        end else
`endif
        begin
          if (row_full) begin
            full_n[rp] = 1'b1;
            count_n    = count + 1'b1;
          end else begin
            if (wp != rp) begin
              wr_en   = 1'b1;
              wr_addr = wp;
              wr_data = rd_data;
            end
            wp_n = wp - 1'b1;
          end
          if (rp == '0) begin
            if (count_n == '0) begin
              lines_n = count_n;
              state_n = DONE;
            end else begin
              state_n = FILL;
            end
          end else begin
            rp_n      = rp - 1'b1;
            rd_addr_n = rp - 1'b1;
            state_n   = READ;
          end
        end
      end

      FILL: begin
        wr_en   = 1'b1;
        wr_addr = wp;
        wr_data = '0;
        wp_n    = wp - 1'b1;
        if (wp == fill_stop) begin
          lines_n = count;
          state_n = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // row_empty only feeds the early-exit path; keep it referenced otherwise.
`ifndef LINE_CLEAR_EARLY_EXIT_EN
  logic unused_row_empty;
  assign unused_row_empty = row_empty;
`endif

endmodule
